// File: rtl/insdecode.sv
// Decode stage: splits the instruction word, generates main control and the
// sign-extended immediate, and holds the 2-read/1-write register file.
module insdecode #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inscode,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DWIDTH-1:0] imm_ext,
  output logic [25:0]       jaddr,
  output logic [DWIDTH-1:0] rd1,
  output logic [DWIDTH-1:0] rd2,
  output logic              reg_dst,
  output logic              alu_src,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump,
  output logic [1:0]        alu_op,
  output logic              illegal
);

  localparam int unsigned IMMW = 16;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;

  logic [DWIDTH-1:0] regs [NREGS];

  // Field split
  assign opcode  = inscode[31:26];
  assign rs      = inscode[25:21];
  assign rt      = inscode[20:16];
  assign rd      = inscode[15:11];
  assign shamt   = inscode[10:6];
  assign funct   = inscode[5:0];
  assign jaddr   = inscode[25:0];
  assign imm_ext = {{(DWIDTH-IMMW){inscode[15]}}, inscode[15:0]};

  // Main control decode; unknown opcodes leave every control deasserted
  always_comb begin
    reg_dst    = 1'b0;
    alu_src    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    alu_op     = ALU_ADD;
    illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_FUNC;
      end
      OP_LW: begin
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
      end
      OP_SW: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BEQ: begin
        branch = 1'b1;
        alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_J:    jump    = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

  // Register file write port; register 0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Asynchronous reads without write bypass, so no loop through writeback
  assign rd1 = (rs == 5'd0) ? '0 : regs[rs];
  assign rd2 = (rt == 5'd0) ? '0 : regs[rt];

endmodule

// File: tb/tb_insdecode.sv
// Self-checking bench for insdecode: directed cases then randomized traffic
// compared against a behavioural register-file and decode-table model.
module tb_insdecode;

  logic        clk;
  logic        reset;
  logic [31:0] inscode;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [31:0] imm_ext;
  logic [25:0] jaddr;
  logic [31:0] rd1, rd2;
  logic        reg_dst, alu_src, mem_to_reg, reg_write;
  logic        mem_read, mem_write, branch, jump;
  logic [1:0]  alu_op;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_regs [32];

  insdecode dut (
    .clk(clk), .reset(reset), .inscode(inscode), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .opcode(opcode), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .funct(funct), .imm_ext(imm_ext), .jaddr(jaddr),
    .rd1(rd1), .rd2(rd2), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .branch(branch), .jump(jump), .alu_op(alu_op),
    .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Edge plus model update; returns at the following negedge
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    end else if (wr_en && wr_addr != 5'd0) begin
      model_regs[wr_addr] = wr_data;
    end
    @(negedge clk);
  endtask

  // Decode table: {reg_dst alu_src mem_to_reg reg_write mem_read mem_write branch jump alu_op}
  function automatic logic [10:0] exp_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return {10'b1001000010, 1'b0};
      6'b100011: return {10'b0111100000, 1'b0};
      6'b101011: return {10'b0100010000, 1'b0};
      6'b000100: return {10'b0000001001, 1'b0};
      6'b001000: return {10'b0101000000, 1'b0};
      6'b000010: return {10'b0000000100, 1'b0};
      default:   return {10'b0000000000, 1'b1};
    endcase
  endfunction

  task automatic check_all();
    int imm;
    logic [10:0] ctl;
    imm = int'(inscode[15:0]);
    if (imm >= 32768) imm = imm - 65536;
    ctl = exp_ctrl(inscode[31:26]);
    check("opcode", 32'(opcode), 32'(inscode >> 26));
    check("rs", 32'(rs), (inscode >> 21) & 32'h1F);
    check("rt", 32'(rt), (inscode >> 16) & 32'h1F);
    check("rd", 32'(rd), (inscode >> 11) & 32'h1F);
    check("shamt", 32'(shamt), (inscode >> 6) & 32'h1F);
    check("funct", 32'(funct), inscode & 32'h3F);
    check("jaddr", 32'(jaddr), inscode & 32'h03FF_FFFF);
    check("imm_ext", imm_ext, 32'(imm));
    check("ctrl", 32'({reg_dst, alu_src, mem_to_reg, reg_write, mem_read,
                       mem_write, branch, jump, alu_op, illegal}), 32'(ctl));
    check("rd1", rd1, model_regs[(inscode >> 21) & 32'h1F]);
    check("rd2", rd2, model_regs[(inscode >> 16) & 32'h1F]);
  endtask

  function automatic logic [31:0] rsrt(input int a, input int b);
    return {6'd0, 5'(a), 5'(b), 16'd0};
  endfunction

  initial begin
    logic [5:0] ops [7];
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    for (int i = 0; i < 32; i++) model_regs[i] = 32'hx;
    reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0; inscode = 32'd0;
    @(negedge clk);
    tick();
    reset = 1'b0;

    // Reset clears all registers
    inscode = rsrt(5, 31);
    #1 check("rst_rd1", rd1, 32'd0);
    check("rst_rd2", rd2, 32'd0);
    for (int a = 0; a < 32; a++) begin
      inscode = rsrt(a, 31 - a);
      #1 check("rst_all_rd1", rd1, 32'd0);
      check("rst_all_rd2", rd2, 32'd0);
    end

    // Write then read, no same-cycle bypass
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF; inscode = rsrt(7, 7);
    #1 check("no_bypass", rd1, 32'd0);
    tick();
    wr_en = 1'b0;
    #1 check("wr7_rd1", rd1, 32'hDEADBEEF);
    check("wr7_rd2_same", rd2, 32'hDEADBEEF);

    // Register 0 discards writes
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; inscode = rsrt(0, 0);
    tick();
    wr_en = 1'b0;
    #1 check("r0_rd1", rd1, 32'd0);

    // Directed decode cases
    inscode = 32'h8C22FFFC;
    #1 check("lw_imm", imm_ext, 32'hFFFFFFFC);
    check("lw_ctl", 32'({mem_read, mem_to_reg, alu_src, reg_write}), 32'hF);
    check("lw_rt", 32'(rt), 32'd2);
    inscode = 32'h00851020;
    #1 check("add_dst_op", 32'({reg_dst, alu_op}), 32'b110);
    check("add_funct", 32'(funct), 32'h20);
    inscode = 32'hFC000000;
    #1 check("ill", 32'({illegal, reg_write, mem_write, branch, jump}), 32'b10000);
    inscode = 32'h08000010;
    #1 check("j_jump", 32'(jump), 32'd1);
    check("j_addr", 32'(jaddr), 32'h10);

    // Reset wins over a simultaneous write
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd5; inscode = rsrt(3, 4);
    tick();
    #1 check("r3_before_rst", rd1, 32'd5);
    reset = 1'b1; wr_addr = 5'd4; wr_data = 32'h12345678;
    tick();
    reset = 1'b0; wr_en = 1'b0;
    #1 check("rst_r3", rd1, 32'd0);
    check("rst_r4", rd2, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      inscode = {ops[$urandom_range(6)], 26'($urandom)};
      if ($urandom_range(7) == 0) inscode[31:26] = 6'($urandom);
      wr_en   = 1'($urandom);
      wr_addr = 5'($urandom);
      wr_data = $urandom;
      reset   = ($urandom_range(31) == 0);
      #1 check_all();
      tick();
    end
    reset = 1'b0; wr_en = 1'b0;
    #1 check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
